// File: rtl/stream_demux4.sv
// stream_demux4: steers one input stream into four independent DEPTH-entry FIFOs; 1-cycle in-to-out latency, per-channel backpressure.
// Build option STREAM_DEMUX4_COUNT_EN enables the 16-bit routed_count transfer counter (otherwise tied to 0).
module stream_demux4 #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_select,
  input  logic [WIDTH-1:0] in_data,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [WIDTH-1:0] out_1,
  output logic [WIDTH-1:0] out_2,
  output logic [WIDTH-1:0] out_3,
  output logic [WIDTH-1:0] out_4,
  output logic [15:0]      routed_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [3:0] full;

  // A full channel never accepts, even when it pops this cycle.
  assign in_ready = !flush && !full[in_select];

  for (genvar c = 0; c < 4; c++) begin : g_ch
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] head;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_nxt;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_rem;
    logic             push;
    logic             pop;

    assign push         = in_valid && in_ready && (in_select == 2'(c));
    assign pop          = (cnt != '0) && out_ready[c] && !flush;
    assign full[c]      = (cnt == CW'(DEPTH));
    assign out_valid[c] = (cnt != '0);
    assign rd_nxt       = rd_ptr + PW'(1);
    assign cnt_rem      = cnt - CW'(pop);

    // head is a register so the output holds its last value once the channel drains.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        cnt    <= '0;
        head   <= '0;
      end else if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_nxt;
        cnt <= cnt_rem + CW'(push);
        if (push && (cnt_rem == '0))
          head <= in_data;
        else if (pop && (cnt_rem != '0))
          head <= mem[rd_nxt];
      end
    end

    always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_data;
    end
  end

  assign out_1 = g_ch[0].head;
  assign out_2 = g_ch[1].head;
  assign out_3 = g_ch[2].head;
  assign out_4 = g_ch[3].head;

`ifdef STREAM_DEMUX4_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      routed_count <= '0;
    else if (in_valid && in_ready)
      routed_count <= routed_count + 16'd1;
  end
`else
  assign routed_count = '0;
`endif

endmodule

// File: tb/tb_stream_demux4.sv
// Self-checking bench for stream_demux4: directed cases plus random traffic against a queue-based reference.
module tb_stream_demux4;
  localparam int WIDTH = 8;
  localparam int DEPTH = 2;

  logic             clk;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_select;
  logic [WIDTH-1:0] in_data;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic [WIDTH-1:0] out_1, out_2, out_3, out_4;
  logic [15:0]      routed_count;
  logic [WIDTH-1:0] dout [4];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: one queue per channel, the last head seen per channel, and a transfer count.
  logic [WIDTH-1:0] mq [4][$];
  logic [WIDTH-1:0] mlast [4];
  logic [15:0]      mcount;

  stream_demux4 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_select(in_select), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_1(out_1), .out_2(out_2), .out_3(out_3), .out_4(out_4),
    .routed_count(routed_count)
  );

  assign dout[0] = out_1;
  assign dout[1] = out_2;
  assign dout[2] = out_3;
  assign dout[3] = out_4;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_count();
`ifdef STREAM_DEMUX4_COUNT_EN
    return mcount;
`else
    return 16'd0;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mq[i].delete();
      mlast[i] = '0;
    end
    mcount = '0;
  endtask

  task automatic check_outs(input string tag);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s.out_valid%0d", tag, i), 32'(out_valid[i]), 32'(mq[i].size() > 0));
      chk($sformatf("%s.out_data%0d", tag, i), 32'(dout[i]), 32'(mlast[i]));
    end
    chk({tag, ".routed_count"}, 32'(routed_count), 32'(exp_count()));
  endtask

  // One clock: check in_ready against the model, clock the DUT, advance the model, check outputs.
  task automatic step(input string tag);
    logic exp_rdy;
    logic acc;
    #1;
    exp_rdy = !flush && (mq[in_select].size() < DEPTH);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(exp_rdy));
    acc = in_valid && exp_rdy;
    @(posedge clk);
    if (flush) begin
      for (int i = 0; i < 4; i++) mq[i].delete();
    end else begin
      for (int i = 0; i < 4; i++)
        if (out_ready[i] && mq[i].size() > 0) void'(mq[i].pop_front());
      if (acc) begin
        mq[in_select].push_back(in_data);
        mcount = mcount + 16'd1;
      end
    end
    for (int i = 0; i < 4; i++)
      if (mq[i].size() > 0) mlast[i] = mq[i][0];
    #1;
    check_outs(tag);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_select = 2'd0; in_data = '0; out_ready = 4'h0;
    model_reset();
    #1;
    check_outs("reset");
    @(posedge clk);
    #1 reset = 1'b0;
    for (int s = 0; s < 4; s++) begin
      in_select = 2'(s);
      #1 chk($sformatf("reset.in_ready_sel%0d", s), 32'(in_ready), 32'd1);
    end

    // Single push to channel 2 appears one cycle later.
    in_valid = 1'b1; in_select = 2'd2; in_data = 8'hA5;
    step("push_a5");
    in_valid = 1'b0;
    chk("push_a5.out_valid", 32'(out_valid), 32'h4);
    chk("push_a5.out_3", 32'(out_3), 32'hA5);

    // Fill channel 1, check backpressure is per-select, then drain in order.
    in_valid = 1'b1; in_select = 2'd1; in_data = 8'h11;
    step("fill1_a");
    in_data = 8'h22;
    step("fill1_b");
    in_valid = 1'b0;
    #1 chk("full1.in_ready_sel1", 32'(in_ready), 32'd0);
    in_select = 2'd0;
    #1 chk("full1.in_ready_sel0", 32'(in_ready), 32'd1);
    chk("drain1.first", 32'(out_2), 32'h11);
    out_ready = 4'b0010;
    step("drain1_a");
    chk("drain1.second", 32'(out_2), 32'h22);
    step("drain1_b");
    chk("drain1.empty", 32'(out_valid[1]), 32'd0);
    out_ready = 4'h0;

    // Full channel 0 popping this cycle still refuses the push; accepted next cycle.
    in_valid = 1'b1; in_select = 2'd0; in_data = 8'h01;
    step("fill0_a");
    in_data = 8'h02;
    step("fill0_b");
    out_ready = 4'b0001; in_data = 8'h33;
    #1 chk("full0_pop.in_ready", 32'(in_ready), 32'd0);
    step("full0_pop");
    #1 chk("after_pop.in_ready", 32'(in_ready), 32'd1);
    step("after_pop");
    in_valid = 1'b0; out_ready = 4'h0;

    // Push and pop together on a one-entry channel 3.
    in_valid = 1'b1; in_select = 2'd3; in_data = 8'h10;
    step("ch3_one");
    out_ready = 4'b1000; in_data = 8'h7E;
    step("ch3_pushpop");
    chk("ch3_pushpop.out_4", 32'(out_4), 32'h7E);
    in_valid = 1'b0; out_ready = 4'h0;
    step("ch3_hold");
    chk("ch3_hold.valid", 32'(out_valid[3]), 32'd1);

    // Clear everything, then random traffic with occasional flush.
    flush = 1'b1;
    step("flush_pre_rand");
    flush = 1'b0;
    for (int n = 0; n < 400; n++) begin
      flush     = ($urandom_range(0, 24) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_select = 2'($urandom_range(0, 3));
      in_data   = 8'($urandom);
      out_ready = 4'($urandom);
      step("rand");
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 4'h0;

    // Fill channels 0 and 2, flush with a push offered, then async reset mid-cycle.
    in_valid = 1'b1;
    for (int k = 0; k < 2 * DEPTH; k++) begin
      in_select = (k % 2 == 0) ? 2'd0 : 2'd2;
      in_data   = 8'(8'h40 + k);
      step("fill02");
    end
    flush = 1'b1; in_select = 2'd1; in_data = 8'h99;
    #1 chk("flush.in_ready", 32'(in_ready), 32'd0);
    step("flush");
    chk("flush.out_valid", 32'(out_valid), 32'd0);
    flush = 1'b0; in_select = 2'd2; in_data = 8'h5C;
    step("refill");
    in_valid = 1'b0;
    #2 reset = 1'b1;
    model_reset();
    #1;
    chk("async_reset.out_valid", 32'(out_valid), 32'd0);
    chk("async_reset.out_3", 32'(out_3), 32'd0);
    chk("async_reset.routed_count", 32'(routed_count), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    for (int s = 0; s < 4; s++) begin
      in_select = 2'(s);
      #1 chk($sformatf("post_reset.in_ready_sel%0d", s), 32'(in_ready), 32'd1);
    end

`ifdef STREAM_DEMUX4_COUNT_EN
    // 65537 transfers wrap the counter to 1.
    in_valid = 1'b1; out_ready = 4'hF;
    for (int n = 0; n < 65537; n++) begin
      in_select = 2'(n % 4);
      in_data   = 8'($urandom);
      step("wrap");
    end
    chk("wrap.routed_count", 32'(routed_count), 32'd1);
`else
    in_valid = 1'b1; out_ready = 4'hF;
    for (int n = 0; n < 20; n++) begin
      in_select = 2'(n % 4);
      in_data   = 8'($urandom);
      step("nocount");
    end
    chk("nocount.routed_count", 32'(routed_count), 32'd0);
`endif
    in_valid = 1'b0; out_ready = 4'h0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
